tx_ptp_field_rewrite: RTL
=========================

Name: tx_ptp_field_rewrite

Overview:
- Parametrised next-generation egress PTP field-rewrite stage. It sits between the TX parser and the one-step timestamp inserter in the TSU egress path.
- Works on an LANES-byte XGMII/GMII-style stream.
- Per frame, it latches the parser metadata and zeroes messageTypeSpecific.
- New relative to the previous generation: it optionally writes the asymmetry-corrected correctionField back into the packet, and it zeroes the IPv4 UDP checksum when it alters a frame.

Parameters:
- LANES, 8, bytes per beat: 8 = XGMII, 4, or 1 = GMII/MII.
- DLY, 3, input delay-line stages before the rewrite stage; minimum 1.
- AW, 11, byte-address width.

Ports:
- tx_clk  in  1  clock
- tx_rst_n  in  1  asynchronous active-low reset
- tx_clk_en_i  in  1  beat enable; all registers hold when low
- txd_i  in  8*LANES  data; lane k = bits [8k+7:8k]
- txc_i  in  LANES  control flags per lane
- eth_count_base_i  in  AW  byte index of lane 0, aligned with txd_i
- sof_i  in  1  level; rising edge marks a new frame
- tsu_cfg_i  in  32  bit0 one_step, bit3 tc_offload, bit5 emb_ingressTime_en, bit6 eg_asym_en, bit7 cf_wr_en, bit8 udp_csum_clr_en
- egress_asymmetry_i  in  32  signed ns
- is_ptp_message_i  in  1  metadata below valid; latch strobe
- ptp_addr_base_i  in  AW  byte index of PTP header start
- ptp_messageType_i  in  4  message type
- ptp_correctionField_i  in  64  ns*2^16
- ptp_messageTypeSpecific_i  in  32  embedded ingress ns
- ipv4_flag_i  in  1  frame is IPv4/UDP
- ipv4_addr_base_i  in  AW  IPv4 header start
- txd_o  out  8*LANES  rewritten data
- txc_o  out  LANES  delayed txc
- eth_count_base_o  out  AW  delayed count, aligned with txd_o
- sof_o  out  1  delayed sof_i, aligned with txd_o
- correctionField_o  out  64  corrected CF of the current frame
- ingress_time_o  out  32  latched messageTypeSpecific
- frame_modified_o  out  1  at least one byte of the current frame was altered

Behaviour:
- Reset values: all outputs 0; context registers cleared with ptp_addr_base = 'h80 and messageType = 4'hF.
- Latency: txd_i/txc_i/eth_count_base_i/sof_i to outputs is exactly DLY+2 enabled beats (DLY delay stages, one rewrite register, one output register).
- Context latch:
  - When is_ptp_message_i=1, capture addr base, type, and ingress time.
  - Capture CF' = ptp_correctionField_i − {sext16(asym), asym, 16'h0} if eg_asym_en and type∈{1,2}; otherwise CF' = ptp_correctionField_i. Arithmetic is mod 2^64.
  - When ipv4_flag_i=1, capture ipv4 base.
  - Context clears on the sof rising edge as seen at the rewrite stage (sof delayed DLY beats).
  - If latch and clear coincide, the latch wins.
- correctionField_o and ingress_time_o update on the beat after the latch.
- Rewrite conditions: evaluated per lane k at the rewrite stage with cnt = eth_count_base_dDLY + k, and only on data lanes (txc=0). Control lanes pass unmodified.
  - ev = ctx_ptp & ~type[3] & (one_step|tc_offload).
  - MTS: ev & emb_ingressTime_en & cnt∈[base+16, base+19] → byte 0.
  - CF: ev & cf_wr_en & cnt = base+8+j (j=0..7) → CF' byte j, big-endian (j=0 is CF'[63:56]).
  - UDP checksum: udp_csum_clr_en & ctx_ipv4 & frame_modified & cnt∈{ipv4base+26, +27} → byte 0. IPv4 IHL=5 only. If the checksum bytes precede the first rewritten byte, they are not cleared; modified_flag is sticky per frame, and this ordering is a documented limitation.
- A field spanning beat boundaries is rewritten across consecutive beats, by byte index only.
- frame_modified_o is set at the first altered byte and clears with the context.
- tx_clk_en_i low freezes all pipeline and context state.
- Reset mid-frame: outputs go to 0 immediately. The remainder of that frame passes unmodified, because the context is empty until the next is_ptp_message_i.
- Count wrap: cnt arithmetic is mod 2^AW; frames longer than 2^AW bytes are unsupported.

Test Plan:
- LANES=8, DLY=3, one_step=1, emb=1, Sync (type 0) at base 0x2A, MTS=0x12345678.
  - Bytes 0x3A..0x3D out as 00.
  - Every other byte unchanged.
  - Latency is 5 beats.
- Delay_Req (type 1), eg_asym_en=1, asym=0x10, CF=0x0000_0000_0064_0000, cf_wr_en=1.
  - correctionField_o = 0x0000_0000_0054_0000.
  - Bytes base+8..15 = 00 00 00 00 00 54 00 00.
- Follow_Up (type 8) with all enables set → output is bit-identical to input, and frame_modified_o=0.
- IPv4 Sync, ipv4 base 0x0E, udp_csum_clr_en=1 → bytes 0x28/0x29 out as 00, and frame_modified_o=1.
- LANES=1 with tx_clk_en_i toggling 1-of-10 → same byte output as LANES=8, with latency 5 enabled beats.
- tx_rst_n pulsed low mid-frame → txd_o/txc_o=0 immediately; the next frame with sof is rewritten correctly.

Source files
------------

// File: rtl/tx_ptp_field_rewrite.sv
// Egress PTP field-rewrite stage: delays the TX stream DLY+2 beats and patches
// messageTypeSpecific, correctionField and the IPv4 UDP checksum in flight.
module tx_ptp_field_rewrite #(
  parameter int unsigned LANES = 8,
  parameter int unsigned DLY   = 3,
  parameter int unsigned AW    = 11
) (
  input  logic                 tx_clk,
  input  logic                 tx_rst_n,
  input  logic                 tx_clk_en_i,
  input  logic [8*LANES-1:0]   txd_i,
  input  logic [LANES-1:0]     txc_i,
  input  logic [AW-1:0]        eth_count_base_i,
  input  logic                 sof_i,
  input  logic [31:0]          tsu_cfg_i,
  input  logic [31:0]          egress_asymmetry_i,
  input  logic                 is_ptp_message_i,
  input  logic [AW-1:0]        ptp_addr_base_i,
  input  logic [3:0]           ptp_messageType_i,
  input  logic [63:0]          ptp_correctionField_i,
  input  logic [31:0]          ptp_messageTypeSpecific_i,
  input  logic                 ipv4_flag_i,
  input  logic [AW-1:0]        ipv4_addr_base_i,
  output logic [8*LANES-1:0]   txd_o,
  output logic [LANES-1:0]     txc_o,
  output logic [AW-1:0]        eth_count_base_o,
  output logic                 sof_o,
  output logic [63:0]          correctionField_o,
  output logic [31:0]          ingress_time_o,
  output logic                 frame_modified_o
);
  localparam int unsigned DW = 8 * LANES;

  logic [DW-1:0]    txd_d [DLY];
  logic [LANES-1:0] txc_d [DLY];
  logic [AW-1:0]    cnt_d [DLY];
  logic             sof_d [DLY];

  logic [DW-1:0]    txd_rw;
  logic [LANES-1:0] txc_rw;
  logic [AW-1:0]    cnt_rw;
  logic             sof_rw;

  logic             ctx_ptp, ctx_ipv4, mod_q;
  logic [AW-1:0]    ctx_base, ctx_ipv4_base;
  logic [3:0]       ctx_type;
  logic [63:0]      ctx_cf;
  logic [31:0]      ctx_mts;

  logic             clr, ptp_act, ipv4_act, ev, run;
  logic [DW-1:0]    txd_new;
  logic [AW-1:0]    cnt_k, off_k, uoff_k;
  logic [63:0]      asym_term, cf_new;
  logic             unused_cfg;

  assign unused_cfg        = ^{tsu_cfg_i[31:9], tsu_cfg_i[4], tsu_cfg_i[2:1]};
  assign correctionField_o = ctx_cf;
  assign ingress_time_o    = ctx_mts;

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      for (int unsigned i = 0; i < DLY; i++) begin
        txd_d[i] <= '0;
        txc_d[i] <= '0;
        cnt_d[i] <= '0;
        sof_d[i] <= 1'b0;
      end
    end else if (tx_clk_en_i) begin
      txd_d[0] <= txd_i;
      txc_d[0] <= txc_i;
      cnt_d[0] <= eth_count_base_i;
      sof_d[0] <= sof_i;
      for (int unsigned i = 1; i < DLY; i++) begin
        txd_d[i] <= txd_d[i-1];
        txc_d[i] <= txc_d[i-1];
        cnt_d[i] <= cnt_d[i-1];
        sof_d[i] <= sof_d[i-1];
      end
    end
  end

  always_comb begin
    asym_term = {{16{egress_asymmetry_i[31]}}, egress_asymmetry_i, 16'h0000};
    cf_new    = ptp_correctionField_i;
    if (tsu_cfg_i[6] && (ptp_messageType_i == 4'd1 || ptp_messageType_i == 4'd2))
      cf_new = ptp_correctionField_i - asym_term;
  end

  // The beat carrying a new sof must not see the previous frame's context,
  // so the pending clear masks it combinationally.
  always_comb begin
    clr      = sof_d[DLY-1] & ~sof_rw;
    ptp_act  = ctx_ptp & ~clr;
    ipv4_act = ctx_ipv4 & ~clr;
    ev       = ptp_act & ~ctx_type[3] & (tsu_cfg_i[0] | tsu_cfg_i[3]);
    run      = mod_q & ~clr;
    txd_new  = txd_d[DLY-1];
    cnt_k    = '0;
    off_k    = '0;
    uoff_k   = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      cnt_k  = cnt_d[DLY-1] + AW'(k);
      off_k  = cnt_k - ctx_base;
      uoff_k = cnt_k - ctx_ipv4_base;
      if (!txc_d[DLY-1][k]) begin
        if (ev && tsu_cfg_i[5] && off_k >= AW'(16) && off_k <= AW'(19)) begin
          txd_new[8*k +: 8] = '0;
          run = 1'b1;
        end else if (ev && tsu_cfg_i[7] && off_k >= AW'(8) && off_k <= AW'(15)) begin
          txd_new[8*k +: 8] = 8'(ctx_cf >> {~off_k[2:0], 3'b000});
          run = 1'b1;
        end else if (tsu_cfg_i[8] && ipv4_act && run &&
                     (uoff_k == AW'(26) || uoff_k == AW'(27))) begin
          txd_new[8*k +: 8] = '0;
        end
      end
    end
  end

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      ctx_ptp       <= 1'b0;
      ctx_ipv4      <= 1'b0;
      ctx_base      <= AW'(8'h80);
      ctx_type      <= 4'hF;
      ctx_cf        <= '0;
      ctx_mts       <= '0;
      ctx_ipv4_base <= '0;
      mod_q         <= 1'b0;
    end else if (tx_clk_en_i) begin
      mod_q <= run;
      if (clr) begin
        ctx_ptp       <= 1'b0;
        ctx_ipv4      <= 1'b0;
        ctx_base      <= AW'(8'h80);
        ctx_type      <= 4'hF;
        ctx_cf        <= '0;
        ctx_mts       <= '0;
        ctx_ipv4_base <= '0;
      end
      if (is_ptp_message_i) begin
        ctx_ptp  <= 1'b1;
        ctx_base <= ptp_addr_base_i;
        ctx_type <= ptp_messageType_i;
        ctx_cf   <= cf_new;
        ctx_mts  <= ptp_messageTypeSpecific_i;
      end
      if (ipv4_flag_i) begin
        ctx_ipv4      <= 1'b1;
        ctx_ipv4_base <= ipv4_addr_base_i;
      end
    end
  end

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      txd_rw           <= '0;
      txc_rw           <= '0;
      cnt_rw           <= '0;
      sof_rw           <= 1'b0;
      txd_o            <= '0;
      txc_o            <= '0;
      eth_count_base_o <= '0;
      sof_o            <= 1'b0;
      frame_modified_o <= 1'b0;
    end else if (tx_clk_en_i) begin
      txd_rw           <= txd_new;
      txc_rw           <= txc_d[DLY-1];
      cnt_rw           <= cnt_d[DLY-1];
      sof_rw           <= sof_d[DLY-1];
      txd_o            <= txd_rw;
      txc_o            <= txc_rw;
      eth_count_base_o <= cnt_rw;
      sof_o            <= sof_rw;
      frame_modified_o <= mod_q;
    end
  end
endmodule
